// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: one-hot control encoding, coin values/codes, default prices.
package vm_pkg;

  localparam int unsigned NUM_STATES = 23;

  typedef logic [0:NUM_STATES-1] ctrl_t;

  typedef enum logic [4:0] {
    ST_IDLE              = 5'd0,
    ST_START_STATE       = 5'd1,
    ST_PRICE_ADMIN       = 5'd2,
    ST_PRICE_UP_JUICE0   = 5'd3,
    ST_PRICE_DOWN_JUICE0 = 5'd4,
    ST_PRICE_UP_JUICE1   = 5'd5,
    ST_PRICE_DOWN_JUICE1 = 5'd6,
    ST_MONEY_INPUT       = 5'd7,
    ST_MONEY_50UP        = 5'd8,
    ST_MONEY_100UP       = 5'd9,
    ST_MONEY_500UP       = 5'd10,
    ST_MONEY_1000UP      = 5'd11,
    ST_MONEY_JUDGE       = 5'd12,
    ST_JUICE0_OUT_READY  = 5'd13,
    ST_JUICE0_OUT_SUC    = 5'd14,
    ST_JUICE1_OUT_READY  = 5'd15,
    ST_JUICE1_OUT_SUC    = 5'd16,
    ST_MONEY_RETURN      = 5'd17,
    ST_MONEY_RETURN_1000 = 5'd18,
    ST_MONEY_RETURN_500  = 5'd19,
    ST_MONEY_RETURN_100  = 5'd20,
    ST_MONEY_RETURN_50   = 5'd21,
    ST_END               = 5'd22
  } state_e;

  // Bit 0 of the [0:22] vector is the MSB and corresponds to IDLE.
  function automatic ctrl_t onehot(state_e s);
    ctrl_t r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  localparam ctrl_t CTRL_IDLE              = onehot(ST_IDLE);
  localparam ctrl_t CTRL_START_STATE       = onehot(ST_START_STATE);
  localparam ctrl_t CTRL_PRICE_ADMIN       = onehot(ST_PRICE_ADMIN);
  localparam ctrl_t CTRL_PRICE_UP_JUICE0   = onehot(ST_PRICE_UP_JUICE0);
  localparam ctrl_t CTRL_PRICE_DOWN_JUICE0 = onehot(ST_PRICE_DOWN_JUICE0);
  localparam ctrl_t CTRL_PRICE_UP_JUICE1   = onehot(ST_PRICE_UP_JUICE1);
  localparam ctrl_t CTRL_PRICE_DOWN_JUICE1 = onehot(ST_PRICE_DOWN_JUICE1);
  localparam ctrl_t CTRL_MONEY_INPUT       = onehot(ST_MONEY_INPUT);
  localparam ctrl_t CTRL_MONEY_50UP        = onehot(ST_MONEY_50UP);
  localparam ctrl_t CTRL_MONEY_100UP       = onehot(ST_MONEY_100UP);
  localparam ctrl_t CTRL_MONEY_500UP       = onehot(ST_MONEY_500UP);
  localparam ctrl_t CTRL_MONEY_1000UP      = onehot(ST_MONEY_1000UP);
  localparam ctrl_t CTRL_MONEY_JUDGE       = onehot(ST_MONEY_JUDGE);
  localparam ctrl_t CTRL_JUICE0_OUT_READY  = onehot(ST_JUICE0_OUT_READY);
  localparam ctrl_t CTRL_JUICE0_OUT_SUC    = onehot(ST_JUICE0_OUT_SUC);
  localparam ctrl_t CTRL_JUICE1_OUT_READY  = onehot(ST_JUICE1_OUT_READY);
  localparam ctrl_t CTRL_JUICE1_OUT_SUC    = onehot(ST_JUICE1_OUT_SUC);
  localparam ctrl_t CTRL_MONEY_RETURN      = onehot(ST_MONEY_RETURN);
  localparam ctrl_t CTRL_MONEY_RETURN_1000 = onehot(ST_MONEY_RETURN_1000);
  localparam ctrl_t CTRL_MONEY_RETURN_500  = onehot(ST_MONEY_RETURN_500);
  localparam ctrl_t CTRL_MONEY_RETURN_100  = onehot(ST_MONEY_RETURN_100);
  localparam ctrl_t CTRL_MONEY_RETURN_50   = onehot(ST_MONEY_RETURN_50);
  localparam ctrl_t CTRL_END               = onehot(ST_END);

  localparam logic [15:0] COIN_VAL_50   = 16'd50;
  localparam logic [15:0] COIN_VAL_100  = 16'd100;
  localparam logic [15:0] COIN_VAL_500  = 16'd500;
  localparam logic [15:0] COIN_VAL_1000 = 16'd1000;

  typedef enum logic [1:0] {
    CODE_50   = 2'd0,
    CODE_100  = 2'd1,
    CODE_500  = 2'd2,
    CODE_1000 = 2'd3
  } coin_code_e;

  localparam int unsigned PRICE0_DEFAULT = 500;
  localparam int unsigned PRICE1_DEFAULT = 800;

endpackage

// File: rtl/vm_price_reg.sv
// One juice price register with clamped up/down stepping; a clamped request simply holds.
module vm_price_reg #(
  parameter int unsigned INIT = 500,
  parameter int unsigned STEP = 50,
  parameter int unsigned MAX  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  output logic [0:15] price
);

  logic [16:0] raised;

  assign raised = {1'b0, price} + 17'(STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      price <= 16'(INIT);
    end else if (up) begin
      if (raised <= 17'(MAX)) price <= raised[15:0];
    end else if (down) begin
      if ({1'b0, price} >= 17'(2 * STEP)) price <= price - 16'(STEP);
    end
  end

endmodule

// File: rtl/vending_datapath.sv
// Vending-machine datapath: decodes the one-hot control vector into money/price/stock/kind updates.
// Optional sales log enabled by defining VM_SALES_LOG_EN.
module vending_datapath
  import vm_pkg::*;
#(
  parameter int unsigned PRICE0_INIT = PRICE0_DEFAULT,
  parameter int unsigned PRICE1_INIT = PRICE1_DEFAULT,
  parameter int unsigned PRICE_STEP  = 50,
  parameter int unsigned PRICE_MAX   = 5000,
  parameter int unsigned MONEY_MAX   = 10000,
  parameter int unsigned STOCK_INIT  = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [0:22] CTRL,
  input  logic        KIND_SEL,
  input  logic        REFILL,
  output logic [0:15] MONEY_NOW,
  output logic        KIND_NOW,
  output logic [0:2]  NUM_NOW,
  output logic [0:15] PRICE0_NOW,
  output logic [0:15] PRICE1_NOW,
  output logic        DISPENSE0,
  output logic        DISPENSE1,
  output logic        COIN_RET,
  output logic [0:1]  COIN_CODE,
  output logic        CTRL_ERR
`ifdef VM_SALES_LOG_EN
  ,
  output logic [0:15] SALES_TOTAL,
  output logic [0:7]  SALES_COUNT
`endif
);

  logic [0:2]  stock0, stock1, stock0_nxt, stock1_nxt;
  logic [0:15] money_nxt;
  logic        kind_nxt, disp0_nxt, disp1_nxt, cret_nxt, err_nxt;
  logic        up0, down0, up1, down1, sale0, sale1;
  logic [15:0] coin_in, coin_out;
  coin_code_e  code_sel, code_nxt;

  vm_price_reg #(.INIT(PRICE0_INIT), .STEP(PRICE_STEP), .MAX(PRICE_MAX)) u_price0 (
    .clk(CLK), .rst(RST), .up(up0), .down(down0), .price(PRICE0_NOW)
  );

  vm_price_reg #(.INIT(PRICE1_INIT), .STEP(PRICE_STEP), .MAX(PRICE_MAX)) u_price1 (
    .clk(CLK), .rst(RST), .up(up1), .down(down1), .price(PRICE1_NOW)
  );

  always_comb begin
    money_nxt  = MONEY_NOW;
    kind_nxt   = KIND_NOW;
    stock0_nxt = stock0;
    stock1_nxt = stock1;
    disp0_nxt  = 1'b0;
    disp1_nxt  = 1'b0;
    cret_nxt   = 1'b0;
    err_nxt    = 1'b0;
    up0 = 1'b0; down0 = 1'b0; up1 = 1'b0; down1 = 1'b0;
    sale0 = 1'b0; sale1 = 1'b0;
    coin_in  = '0;
    coin_out = '0;
    code_sel = CODE_50;
    // Zero or multi-hot vectors fall to default and only raise the error pulse.
    case (CTRL)
      CTRL_IDLE: if (REFILL) begin
        stock0_nxt = 3'(STOCK_INIT);
        stock1_nxt = 3'(STOCK_INIT);
      end
      CTRL_START_STATE, CTRL_PRICE_ADMIN, CTRL_MONEY_INPUT: kind_nxt = KIND_SEL;
      CTRL_PRICE_UP_JUICE0:   up0   = 1'b1;
      CTRL_PRICE_DOWN_JUICE0: down0 = 1'b1;
      CTRL_PRICE_UP_JUICE1:   up1   = 1'b1;
      CTRL_PRICE_DOWN_JUICE1: down1 = 1'b1;
      CTRL_MONEY_50UP:   coin_in = COIN_VAL_50;
      CTRL_MONEY_100UP:  coin_in = COIN_VAL_100;
      CTRL_MONEY_500UP:  coin_in = COIN_VAL_500;
      CTRL_MONEY_1000UP: coin_in = COIN_VAL_1000;
      CTRL_MONEY_JUDGE, CTRL_MONEY_RETURN: ;
      CTRL_JUICE0_OUT_READY:
        if (stock0 != 3'd0 && MONEY_NOW >= PRICE0_NOW) begin
          money_nxt  = MONEY_NOW - PRICE0_NOW;
          stock0_nxt = stock0 - 3'd1;
          sale0      = 1'b1;
        end else err_nxt = 1'b1;
      CTRL_JUICE1_OUT_READY:
        if (stock1 != 3'd0 && MONEY_NOW >= PRICE1_NOW) begin
          money_nxt  = MONEY_NOW - PRICE1_NOW;
          stock1_nxt = stock1 - 3'd1;
          sale1      = 1'b1;
        end else err_nxt = 1'b1;
      CTRL_JUICE0_OUT_SUC: disp0_nxt = 1'b1;
      CTRL_JUICE1_OUT_SUC: disp1_nxt = 1'b1;
      CTRL_MONEY_RETURN_1000: begin coin_out = COIN_VAL_1000; code_sel = CODE_1000; end
      CTRL_MONEY_RETURN_500:  begin coin_out = COIN_VAL_500;  code_sel = CODE_500;  end
      CTRL_MONEY_RETURN_100:  begin coin_out = COIN_VAL_100;  code_sel = CODE_100;  end
      CTRL_MONEY_RETURN_50:   begin coin_out = COIN_VAL_50;   code_sel = CODE_50;   end
      CTRL_END: money_nxt = '0;
      default: err_nxt = 1'b1;
    endcase
    if (coin_in != '0) begin
      if ({1'b0, MONEY_NOW} + {1'b0, coin_in} <= 17'(MONEY_MAX)) money_nxt = MONEY_NOW + coin_in;
      else err_nxt = 1'b1;
    end
    if (coin_out != '0) begin
      if (MONEY_NOW >= coin_out) begin
        money_nxt = MONEY_NOW - coin_out;
        cret_nxt  = 1'b1;
      end else err_nxt = 1'b1;
    end
    code_nxt = cret_nxt ? code_sel : CODE_50;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      MONEY_NOW <= '0;
      KIND_NOW  <= 1'b0;
      stock0    <= 3'(STOCK_INIT);
      stock1    <= 3'(STOCK_INIT);
      DISPENSE0 <= 1'b0;
      DISPENSE1 <= 1'b0;
      COIN_RET  <= 1'b0;
      COIN_CODE <= CODE_50;
      CTRL_ERR  <= 1'b0;
    end else begin
      MONEY_NOW <= money_nxt;
      KIND_NOW  <= kind_nxt;
      stock0    <= stock0_nxt;
      stock1    <= stock1_nxt;
      DISPENSE0 <= disp0_nxt;
      DISPENSE1 <= disp1_nxt;
      COIN_RET  <= cret_nxt;
      COIN_CODE <= code_nxt;
      CTRL_ERR  <= err_nxt;
    end
  end

  assign NUM_NOW = KIND_NOW ? stock1 : stock0;

`ifdef VM_SALES_LOG_EN
  logic [15:0] sale_price;
  logic [16:0] total_sum;

  assign sale_price = sale1 ? PRICE1_NOW : PRICE0_NOW;
  assign total_sum  = {1'b0, SALES_TOTAL} + {1'b0, sale_price};

  always_ff @(posedge CLK) begin
    if (RST) begin
      SALES_TOTAL <= '0;
      SALES_COUNT <= '0;
    end else if (sale0 || sale1) begin
      SALES_TOTAL <= total_sum[16] ? '1 : total_sum[15:0];
      SALES_COUNT <= SALES_COUNT + 8'd1;
    end
  end
`else
  logic unused_sale;
  assign unused_sale = sale0 ^ sale1;
`endif

endmodule

// File: tb/tb_vending_datapath.sv
// Self-checking bench for vending_datapath: directed scenarios plus randomized control vectors vs. a behavioural model.
module tb_vending_datapath;

  localparam int I_IDLE = 0,  I_START = 1, I_ADMIN = 2, I_UP0 = 3, I_DN0 = 4, I_UP1 = 5, I_DN1 = 6;
  localparam int I_MINPUT = 7, I_M50 = 8, I_M100 = 9, I_M500 = 10, I_M1000 = 11, I_JUDGE = 12;
  localparam int I_RDY0 = 13, I_SUC0 = 14, I_RDY1 = 15, I_SUC1 = 16, I_MRET = 17;
  localparam int I_R1000 = 18, I_R500 = 19, I_R100 = 20, I_R50 = 21, I_END = 22;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [0:22] CTRL = '0;
  logic        KIND_SEL = 1'b0;
  logic        REFILL = 1'b0;
  logic [0:15] MONEY_NOW, PRICE0_NOW, PRICE1_NOW;
  logic        KIND_NOW, DISPENSE0, DISPENSE1, COIN_RET, CTRL_ERR;
  logic [0:2]  NUM_NOW;
  logic [0:1]  COIN_CODE;
`ifdef VM_SALES_LOG_EN
  logic [0:15] SALES_TOTAL;
  logic [0:7]  SALES_COUNT;
`endif

  vending_datapath dut (
    .CLK(CLK), .RST(RST), .CTRL(CTRL), .KIND_SEL(KIND_SEL), .REFILL(REFILL),
    .MONEY_NOW(MONEY_NOW), .KIND_NOW(KIND_NOW), .NUM_NOW(NUM_NOW),
    .PRICE0_NOW(PRICE0_NOW), .PRICE1_NOW(PRICE1_NOW),
    .DISPENSE0(DISPENSE0), .DISPENSE1(DISPENSE1),
    .COIN_RET(COIN_RET), .COIN_CODE(COIN_CODE), .CTRL_ERR(CTRL_ERR)
`ifdef VM_SALES_LOG_EN
    , .SALES_TOTAL(SALES_TOTAL), .SALES_COUNT(SALES_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers).
  int m_money, m_kind, m_p0, m_p1, m_s0, m_s1;
  int m_d0, m_d1, m_cr, m_code, m_err, m_total, m_count;

  function automatic logic [0:22] vec(input int i);
    logic [0:22] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input logic [0:22] v, input logic ks, input logic rf, input logic rst);
    int idx;
    int up_val[4]  = '{50, 100, 500, 1000};
    int ret_val[4] = '{1000, 500, 100, 50};
    int ret_cd[4]  = '{3, 2, 1, 0};
    m_d0 = 0; m_d1 = 0; m_cr = 0; m_code = 0; m_err = 0;
    if (rst) begin
      m_money = 0; m_kind = 0; m_p0 = 500; m_p1 = 800; m_s0 = 5; m_s1 = 5;
      m_total = 0; m_count = 0;
      return;
    end
    if ($countones(v) != 1) begin
      m_err = 1;
      return;
    end
    idx = 0;
    for (int i = 0; i < 23; i++) if (v[i]) idx = i;
    case (idx)
      I_IDLE: if (rf) begin m_s0 = 5; m_s1 = 5; end
      I_START, I_ADMIN, I_MINPUT: m_kind = int'(ks);
      I_UP0: if (m_p0 + 50 <= 5000) m_p0 += 50;
      I_DN0: if (m_p0 - 50 >= 50) m_p0 -= 50;
      I_UP1: if (m_p1 + 50 <= 5000) m_p1 += 50;
      I_DN1: if (m_p1 - 50 >= 50) m_p1 -= 50;
      I_M50, I_M100, I_M500, I_M1000:
        if (m_money + up_val[idx - I_M50] <= 10000) m_money += up_val[idx - I_M50];
        else m_err = 1;
      I_RDY0, I_RDY1: begin
        int p;
        int s;
        p = (idx == I_RDY0) ? m_p0 : m_p1;
        s = (idx == I_RDY0) ? m_s0 : m_s1;
        if (s > 0 && m_money >= p) begin
          m_money -= p;
          if (idx == I_RDY0) m_s0--; else m_s1--;
          m_total = (m_total + p > 65535) ? 65535 : m_total + p;
          m_count = (m_count + 1) % 256;
        end else m_err = 1;
      end
      I_SUC0: m_d0 = 1;
      I_SUC1: m_d1 = 1;
      I_R1000, I_R500, I_R100, I_R50:
        if (m_money >= ret_val[idx - I_R1000]) begin
          m_money -= ret_val[idx - I_R1000];
          m_cr = 1;
          m_code = ret_cd[idx - I_R1000];
        end else m_err = 1;
      I_END: m_money = 0;
      default: ;
    endcase
  endtask

  task automatic cyc(input logic [0:22] v, input logic ks, input logic rf, input logic rst);
    @(negedge CLK);
    CTRL = v; KIND_SEL = ks; REFILL = rf; RST = rst;
    @(posedge CLK);
    model_step(v, ks, rf, rst);
    #1;
  endtask

  task automatic test_reset();
    cyc('0, 1'b0, 1'b0, 1'b1);
    checks++; if (MONEY_NOW !== 16'd0) begin errors++; $display("FAIL reset_money got %0d exp 0", MONEY_NOW); end
    checks++; if (KIND_NOW !== 1'b0) begin errors++; $display("FAIL reset_kind got %0d exp 0", KIND_NOW); end
    checks++; if (NUM_NOW !== 3'd5) begin errors++; $display("FAIL reset_num got %0d exp 5", NUM_NOW); end
    checks++; if (PRICE0_NOW !== 16'd500 || PRICE1_NOW !== 16'd800) begin
      errors++; $display("FAIL reset_prices got %0d/%0d exp 500/800", PRICE0_NOW, PRICE1_NOW); end
    checks++; if ({DISPENSE0, DISPENSE1, COIN_RET, COIN_CODE, CTRL_ERR} !== 6'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 000000", {DISPENSE0, DISPENSE1, COIN_RET, COIN_CODE, CTRL_ERR}); end
  endtask

  task automatic test_purchase();
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc(vec(I_M1000), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M500), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd1500) begin errors++; $display("FAIL buy_money_in got %0d exp 1500", MONEY_NOW); end
    cyc(vec(I_MINPUT), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_RDY0), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd1000) begin errors++; $display("FAIL buy_money_after got %0d exp 1000", MONEY_NOW); end
    checks++; if (NUM_NOW !== 3'd4) begin errors++; $display("FAIL buy_stock got %0d exp 4", NUM_NOW); end
    checks++; if (DISPENSE0 !== 1'b0) begin errors++; $display("FAIL buy_no_early_dispense got %0d exp 0", DISPENSE0); end
    cyc(vec(I_SUC0), 1'b0, 1'b0, 1'b0);
    checks++; if (DISPENSE0 !== 1'b1 || DISPENSE1 !== 1'b0) begin
      errors++; $display("FAIL buy_dispense got %0d%0d exp 10", DISPENSE0, DISPENSE1); end
    cyc(vec(I_IDLE), 1'b0, 1'b0, 1'b0);
    checks++; if (DISPENSE0 !== 1'b0) begin errors++; $display("FAIL buy_dispense_end got %0d exp 0", DISPENSE0); end
  endtask

  task automatic test_coin_return();
    logic [0:1] exp_code[3] = '{2'd2, 2'd1, 2'd0};
    int exp_money[3] = '{150, 50, 0};
    int rets[3] = '{I_R500, I_R100, I_R50};
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc(vec(I_M500), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M100), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M50), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd650) begin errors++; $display("FAIL ret_money_in got %0d exp 650", MONEY_NOW); end
    for (int i = 0; i < 3; i++) begin
      cyc(vec(rets[i]), 1'b0, 1'b0, 1'b0);
      checks++; if (COIN_RET !== 1'b1 || COIN_CODE !== exp_code[i] || MONEY_NOW !== 16'(exp_money[i])) begin
        errors++; $display("FAIL ret_step%0d got ret=%0d code=%0d money=%0d exp 1/%0d/%0d",
                           i, COIN_RET, COIN_CODE, MONEY_NOW, exp_code[i], exp_money[i]); end
    end
    cyc(vec(I_R50), 1'b0, 1'b0, 1'b0);
    checks++; if (COIN_RET !== 1'b0 || COIN_CODE !== 2'd0 || CTRL_ERR !== 1'b1 || MONEY_NOW !== 16'd0) begin
      errors++; $display("FAIL ret_empty got ret=%0d code=%0d err=%0d money=%0d exp 0/0/1/0",
                         COIN_RET, COIN_CODE, CTRL_ERR, MONEY_NOW); end
  endtask

  task automatic test_price_clamp();
    cyc('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(vec(I_DN0), 1'b0, 1'b0, 1'b0);
    checks++; if (PRICE0_NOW !== 16'd50 || CTRL_ERR !== 1'b0) begin
      errors++; $display("FAIL price_low got %0d err=%0d exp 50 err=0", PRICE0_NOW, CTRL_ERR); end
    for (int i = 0; i < 90; i++) cyc(vec(I_UP1), 1'b0, 1'b0, 1'b0);
    checks++; if (PRICE1_NOW !== 16'd5000 || CTRL_ERR !== 1'b0) begin
      errors++; $display("FAIL price_high got %0d err=%0d exp 5000 err=0", PRICE1_NOW, CTRL_ERR); end
    checks++; if (PRICE0_NOW !== 16'd50) begin errors++; $display("FAIL price_indep got %0d exp 50", PRICE0_NOW); end
  endtask

  task automatic test_ceiling_illegal();
    cyc('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(vec(I_M1000), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M500), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd9500 || CTRL_ERR !== 1'b0) begin
      errors++; $display("FAIL ceil_fill got %0d err=%0d exp 9500 err=0", MONEY_NOW, CTRL_ERR); end
    cyc(vec(I_M1000), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd9500 || CTRL_ERR !== 1'b1) begin
      errors++; $display("FAIL ceil_block got %0d err=%0d exp 9500 err=1", MONEY_NOW, CTRL_ERR); end
    cyc('0, 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd9500 || CTRL_ERR !== 1'b1) begin
      errors++; $display("FAIL ctrl_zero got %0d err=%0d exp 9500 err=1", MONEY_NOW, CTRL_ERR); end
    cyc(vec(I_M50) | vec(I_END), 1'b1, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd9500 || CTRL_ERR !== 1'b1 || KIND_NOW !== 1'b0 || PRICE0_NOW !== 16'd500) begin
      errors++; $display("FAIL ctrl_multi got money=%0d err=%0d kind=%0d p0=%0d exp 9500/1/0/500",
                         MONEY_NOW, CTRL_ERR, KIND_NOW, PRICE0_NOW); end
    cyc(vec(I_END), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd0 || CTRL_ERR !== 1'b0) begin
      errors++; $display("FAIL end_clear got %0d err=%0d exp 0 err=0", MONEY_NOW, CTRL_ERR); end
  endtask

  task automatic test_stock_refill();
    cyc('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(vec(I_M1000), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_MINPUT), 1'b1, 1'b0, 1'b0);
    checks++; if (KIND_NOW !== 1'b1 || NUM_NOW !== 3'd5) begin
      errors++; $display("FAIL kind_sel got kind=%0d num=%0d exp 1/5", KIND_NOW, NUM_NOW); end
    for (int i = 0; i < 5; i++) cyc(vec(I_RDY1), 1'b1, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd2000 || NUM_NOW !== 3'd0) begin
      errors++; $display("FAIL stock_drain got money=%0d num=%0d exp 2000/0", MONEY_NOW, NUM_NOW); end
    cyc(vec(I_RDY1), 1'b1, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd2000 || NUM_NOW !== 3'd0 || CTRL_ERR !== 1'b1) begin
      errors++; $display("FAIL stock_empty got money=%0d num=%0d err=%0d exp 2000/0/1", MONEY_NOW, NUM_NOW, CTRL_ERR); end
    cyc(vec(I_START), 1'b1, 1'b1, 1'b0);
    checks++; if (NUM_NOW !== 3'd0) begin errors++; $display("FAIL refill_ignored got %0d exp 0", NUM_NOW); end
    cyc(vec(I_IDLE), 1'b1, 1'b1, 1'b0);
    checks++; if (NUM_NOW !== 3'd5 || CTRL_ERR !== 1'b0) begin
      errors++; $display("FAIL refill got num=%0d err=%0d exp 5/0", NUM_NOW, CTRL_ERR); end
  endtask

  task automatic test_reset_mid();
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc(vec(I_MINPUT), 1'b1, 1'b0, 1'b0);
    cyc(vec(I_UP0), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M1000), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M100), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_M100), 1'b0, 1'b0, 1'b0);
    checks++; if (MONEY_NOW !== 16'd1200 || PRICE0_NOW !== 16'd550) begin
      errors++; $display("FAIL mid_setup got money=%0d p0=%0d exp 1200/550", MONEY_NOW, PRICE0_NOW); end
    cyc(vec(I_MRET), 1'b0, 1'b1, 1'b1);
    checks++; if (MONEY_NOW !== 16'd0 || KIND_NOW !== 1'b0 || PRICE0_NOW !== 16'd500 || NUM_NOW !== 3'd5
                  || CTRL_ERR !== 1'b0 || COIN_RET !== 1'b0) begin
      errors++; $display("FAIL mid_reset got money=%0d kind=%0d p0=%0d num=%0d err=%0d exp 0/0/500/5/0",
                         MONEY_NOW, KIND_NOW, PRICE0_NOW, NUM_NOW, CTRL_ERR); end
  endtask

`ifdef VM_SALES_LOG_EN
  task automatic test_sales_log();
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc(vec(I_M1000), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_RDY0), 1'b0, 1'b0, 1'b0);
    cyc(vec(I_RDY0), 1'b0, 1'b0, 1'b0);
    checks++; if (SALES_TOTAL !== 16'd1000 || SALES_COUNT !== 8'd2) begin
      errors++; $display("FAIL sales_log got %0d/%0d exp 1000/2", SALES_TOTAL, SALES_COUNT); end
  endtask
`endif

  task automatic test_random();
    logic [0:22] v;
    logic rst;
    int r, a, b;
    cyc('0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 199);
      rst = (r == 0);
      if (r < 12) begin
        if (r < 4) v = '0;
        else begin
          a = $urandom_range(0, 22);
          b = (a + 1 + $urandom_range(0, 21)) % 23;
          v = vec(a) | vec(b);
        end
      end else if (r < 80) v = vec(I_M50 + $urandom_range(0, 3));
      else v = vec($urandom_range(0, 22));
      cyc(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), rst);
      checks++; if (MONEY_NOW !== 16'(m_money)) begin errors++; $display("FAIL rnd_money cyc%0d got %0d exp %0d", n, MONEY_NOW, m_money); end
      checks++; if (KIND_NOW !== 1'(m_kind)) begin errors++; $display("FAIL rnd_kind cyc%0d got %0d exp %0d", n, KIND_NOW, m_kind); end
      checks++; if (NUM_NOW !== 3'(m_kind ? m_s1 : m_s0)) begin
        errors++; $display("FAIL rnd_num cyc%0d got %0d exp %0d", n, NUM_NOW, m_kind ? m_s1 : m_s0); end
      checks++; if (PRICE0_NOW !== 16'(m_p0) || PRICE1_NOW !== 16'(m_p1)) begin
        errors++; $display("FAIL rnd_price cyc%0d got %0d/%0d exp %0d/%0d", n, PRICE0_NOW, PRICE1_NOW, m_p0, m_p1); end
      checks++; if ({DISPENSE0, DISPENSE1, COIN_RET, COIN_CODE, CTRL_ERR} !==
                    {1'(m_d0), 1'(m_d1), 1'(m_cr), 2'(m_code), 1'(m_err)}) begin
        errors++; $display("FAIL rnd_pulses cyc%0d got d0=%0d d1=%0d ret=%0d code=%0d err=%0d exp %0d %0d %0d %0d %0d",
                           n, DISPENSE0, DISPENSE1, COIN_RET, COIN_CODE, CTRL_ERR, m_d0, m_d1, m_cr, m_code, m_err); end
`ifdef VM_SALES_LOG_EN
      checks++; if (SALES_TOTAL !== 16'(m_total) || SALES_COUNT !== 8'(m_count)) begin
        errors++; $display("FAIL rnd_sales cyc%0d got %0d/%0d exp %0d/%0d", n, SALES_TOTAL, SALES_COUNT, m_total, m_count); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_coin_return();
    test_price_clamp();
    test_ceiling_illegal();
    test_stock_refill();
    test_reset_mid();
`ifdef VM_SALES_LOG_EN
    test_sales_log();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
